// File: rtl/zpu_sd_bridge.sv
// Bridge between the ZPU firmware I/O registers, the hps_io SD block interface and
// port B of the 512-byte sector buffer; also tracks image mount state for firmware.
module zpu_sd_bridge #(
    parameter logic [23:0] ACK_TIMEOUT = 24'd0
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        zpu_lba_sel,
    input  logic        zpu_block_rd,
    input  logic        zpu_block_wr,
    input  logic        zpu_io_wr,
    input  logic        zpu_data_wr,
    input  logic        zpu_data_rd,
    input  logic [31:0] zpu_wdata,
    output logic [7:0]  zpu_status,
    output logic [31:0] zpu_rdata,
    output logic        io_err,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    output logic [8:0]  buf_addr,
    output logic [7:0]  buf_wdata,
    output logic        buf_we,
    input  logic [7:0]  buf_q,
    input  logic        img_mounted,
    input  logic [63:0] img_size,
    input  logic [7:0]  ioctl_index
);

    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

    state_t      state, state_next;
    logic        data_wr_d1, data_wr_d2, data_rd_prev;
    logic        block_rd_prev, block_wr_prev, ack_prev, mount_prev;
    logic [23:0] wait_cnt;
    logic        readonly, mounted, io_done;
    logic [1:0]  filetype;
    logic [2:0]  fileno;
    logic [31:0] filesize;

    logic data_wr_evt, data_rd_fall, block_rd_rise, block_wr_rise, ack_fall, mount_rise;
    logic start_rd, start_wr, ack_seen, timeout_hit, xfer_done;

    // The write strobe is deliberately seen two cycles late; the other detectors act at once.
    assign data_wr_evt   = data_wr_d1 & ~data_wr_d2;
    assign data_rd_fall  = data_rd_prev & ~zpu_data_rd;
    assign block_rd_rise = zpu_block_rd & ~block_rd_prev;
    assign block_wr_rise = zpu_block_wr & ~block_wr_prev;
    assign ack_fall      = ack_prev & ~sd_ack;
    assign mount_rise    = img_mounted & ~mount_prev;

    assign zpu_status = {readonly, filetype, fileno, mounted, io_done};
    assign zpu_rdata  = zpu_lba_sel ? filesize : {24'd0, buf_q};

    logic unused_bits;
    assign unused_bits = ^{img_size[63:32], ioctl_index[5:0]};

    always_ff @(posedge clk_sys) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_next  = state;
        start_rd    = 1'b0;
        start_wr    = 1'b0;
        ack_seen    = 1'b0;
        timeout_hit = 1'b0;
        xfer_done   = 1'b0;
        case (state)
            IDLE: begin
                if (block_rd_rise) begin
                    start_rd   = 1'b1;
                    state_next = REQ;
                end else if (block_wr_rise) begin
                    start_wr   = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (sd_ack) begin
                    ack_seen   = 1'b1;
                    state_next = XFER;
                end else if (ACK_TIMEOUT != 24'd0 && wait_cnt + 24'd1 == ACK_TIMEOUT) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end
            end
            XFER: begin
                if (ack_fall) begin
                    xfer_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            data_wr_d1    <= zpu_data_wr;
            data_wr_d2    <= zpu_data_wr;
            data_rd_prev  <= zpu_data_rd;
            block_rd_prev <= zpu_block_rd;
            block_wr_prev <= zpu_block_wr;
            ack_prev      <= sd_ack;
            mount_prev    <= img_mounted;
            sd_rd         <= 1'b0;
            sd_wr         <= 1'b0;
            buf_we        <= 1'b0;
            buf_wdata     <= 8'd0;
            io_err        <= 1'b0;
            buf_addr      <= 9'd0;
            sd_lba        <= 32'd0;
            wait_cnt      <= 24'd0;
            io_done       <= 1'b1;
            fileno        <= 3'd0;
            filetype      <= 2'd0;
            readonly      <= 1'b0;
            filesize      <= 32'd0;
            mounted       <= |img_size[31:0];
        end else begin
            data_wr_d1    <= zpu_data_wr;
            data_wr_d2    <= data_wr_d1;
            data_rd_prev  <= zpu_data_rd;
            block_rd_prev <= zpu_block_rd;
            block_wr_prev <= zpu_block_wr;
            ack_prev      <= sd_ack;
            mount_prev    <= img_mounted;

            buf_we <= data_wr_evt & ~zpu_lba_sel;
            if (data_wr_evt && !zpu_lba_sel) buf_wdata <= zpu_wdata[7:0];
            if (data_wr_evt && zpu_lba_sel)  sd_lba    <= zpu_wdata;

            // The address advances after the buffer write has used it; io_wr always wins.
            if (zpu_io_wr)                  buf_addr <= 9'd0;
            else if (buf_we || data_rd_fall) buf_addr <= buf_addr + 9'd1;

            if (state == REQ) wait_cnt <= wait_cnt + 24'd1;
            if (start_rd || start_wr) begin
                sd_rd    <= start_rd;
                sd_wr    <= start_wr;
                io_done  <= 1'b0;
                io_err   <= 1'b0;
                wait_cnt <= 24'd0;
            end
            if (ack_seen || timeout_hit) begin
                sd_rd <= 1'b0;
                sd_wr <= 1'b0;
            end
            if (timeout_hit) begin
                io_err  <= 1'b1;
                io_done <= 1'b1;
            end
            if (xfer_done) io_done <= 1'b1;

            if (mount_rise) begin
                fileno   <= 3'd0;
                filetype <= ioctl_index[7:6];
                readonly <= 1'b1;
                mounted  <= ~mounted;
                filesize <= img_size[31:0];
            end
        end
    end

endmodule

// File: tb/tb_zpu_sd_bridge.sv
// Directed bench for zpu_sd_bridge: reset state, LBA/buffer paths, address wrap,
// block request handshake, ack timeout and mount handling.
module tb_zpu_sd_bridge;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        zpu_lba_sel, zpu_block_rd, zpu_block_wr, zpu_io_wr;
    logic        zpu_data_wr, zpu_data_rd;
    logic [31:0] zpu_wdata;
    logic [7:0]  zpu_status;
    logic [31:0] zpu_rdata;
    logic        io_err;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, sd_ack;
    logic [8:0]  buf_addr;
    logic [7:0]  buf_wdata;
    logic        buf_we;
    logic [7:0]  buf_q;
    logic        img_mounted;
    logic [63:0] img_size;
    logic [7:0]  ioctl_index;

    int tests = 0;
    int fails = 0;

    always #5 clk_sys = ~clk_sys;

    zpu_sd_bridge #(.ACK_TIMEOUT(24'd16)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .zpu_lba_sel(zpu_lba_sel), .zpu_block_rd(zpu_block_rd), .zpu_block_wr(zpu_block_wr),
        .zpu_io_wr(zpu_io_wr), .zpu_data_wr(zpu_data_wr), .zpu_data_rd(zpu_data_rd),
        .zpu_wdata(zpu_wdata), .zpu_status(zpu_status), .zpu_rdata(zpu_rdata),
        .io_err(io_err), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .buf_addr(buf_addr), .buf_wdata(buf_wdata), .buf_we(buf_we), .buf_q(buf_q),
        .img_mounted(img_mounted), .img_size(img_size), .ioctl_index(ioctl_index)
    );

    // Advance one clock; outputs are then sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic rd_pulse();
        zpu_data_rd = 1'b1;
        tick();
        zpu_data_rd = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; zpu_lba_sel = 1'b0; zpu_block_rd = 1'b0; zpu_block_wr = 1'b0;
        zpu_io_wr = 1'b0; zpu_data_wr = 1'b0; zpu_data_rd = 1'b0; zpu_wdata = 32'd0;
        sd_ack = 1'b0; buf_q = 8'h5A; img_mounted = 1'b0; img_size = 64'd16384;
        ioctl_index = 8'h00;
        tick(); tick();
        reset = 1'b0;
        tick();
        tests++; if (zpu_status !== 8'h03) begin fails++; $display("FAIL reset_status got %h exp 03", zpu_status); end
        tests++; if (sd_rd !== 1'b0 || sd_wr !== 1'b0) begin fails++; $display("FAIL reset_req got rd=%b wr=%b exp 0/0", sd_rd, sd_wr); end
        tests++; if (buf_addr !== 9'd0) begin fails++; $display("FAIL reset_addr got %0d exp 0", buf_addr); end
        tests++; if (io_err !== 1'b0 || buf_we !== 1'b0) begin fails++; $display("FAIL reset_err_we got err=%b we=%b exp 0/0", io_err, buf_we); end
        tests++; if (sd_lba !== 32'd0) begin fails++; $display("FAIL reset_lba got %h exp 0", sd_lba); end
        tests++; if (zpu_rdata !== 32'h0000_005A) begin fails++; $display("FAIL rdata_buf got %h exp 5a", zpu_rdata); end
        zpu_lba_sel = 1'b1; #1;
        tests++; if (zpu_rdata !== 32'd0) begin fails++; $display("FAIL rdata_filesize_reset got %h exp 0", zpu_rdata); end
        zpu_lba_sel = 1'b0;
    endtask

    task automatic test_lba_write();
        logic we_seen;
        we_seen = 1'b0;
        zpu_lba_sel = 1'b1; zpu_wdata = 32'h0000_0123; zpu_data_wr = 1'b1;
        tick();
        zpu_data_wr = 1'b0;
        we_seen = we_seen | buf_we;
        tests++; if (sd_lba !== 32'd0) begin fails++; $display("FAIL lba_early got %h exp 0", sd_lba); end
        tick();
        we_seen = we_seen | buf_we;
        tests++; if (sd_lba !== 32'h123) begin fails++; $display("FAIL lba_load got %h exp 123", sd_lba); end
        for (int i = 0; i < 3; i++) begin
            tick();
            we_seen = we_seen | buf_we;
        end
        tests++; if (we_seen !== 1'b0) begin fails++; $display("FAIL lba_no_we got %b exp 0", we_seen); end
        zpu_lba_sel = 1'b0;
    endtask

    task automatic test_buf_write();
        zpu_io_wr = 1'b1; tick(); zpu_io_wr = 1'b0;
        tests++; if (buf_addr !== 9'd0) begin fails++; $display("FAIL io_wr_clear got %0d exp 0", buf_addr); end
        for (int k = 0; k < 3; k++) begin
            zpu_wdata = 32'hFFFF_FFA1 + 32'(k); zpu_data_wr = 1'b1;
            tick();
            zpu_data_wr = 1'b0;
            tick();
            tests++;
            if (buf_we !== 1'b1 || buf_addr !== 9'(k) || buf_wdata !== 8'hA1 + 8'(k)) begin
                fails++;
                $display("FAIL buf_wr%0d got we=%b addr=%0d data=%h exp 1/%0d/%h", k, buf_we, buf_addr, buf_wdata, k, 8'hA1 + 8'(k));
            end
            tick();
            tests++; if (buf_we !== 1'b0) begin fails++; $display("FAIL buf_we_pulse%0d got %b exp 0", k, buf_we); end
        end
        tests++; if (buf_addr !== 9'd3) begin fails++; $display("FAIL buf_addr_after got %0d exp 3", buf_addr); end
    endtask

    task automatic test_read_and_wrap();
        zpu_data_rd = 1'b1; tick();
        tests++; if (buf_addr !== 9'd3) begin fails++; $display("FAIL rd_rise_no_inc got %0d exp 3", buf_addr); end
        zpu_data_rd = 1'b0; tick();
        tests++; if (buf_addr !== 9'd4) begin fails++; $display("FAIL rd_fall_inc got %0d exp 4", buf_addr); end
        for (int i = 4; i < 511; i++) rd_pulse();
        tests++; if (buf_addr !== 9'd511) begin fails++; $display("FAIL addr_511 got %0d exp 511", buf_addr); end
        zpu_wdata = 32'h0000_00EE; zpu_data_wr = 1'b1; tick(); zpu_data_wr = 1'b0; tick();
        tests++; if (buf_we !== 1'b1 || buf_addr !== 9'd511) begin fails++; $display("FAIL wrap_we got we=%b addr=%0d exp 1/511", buf_we, buf_addr); end
        tick();
        tests++; if (buf_addr !== 9'd0) begin fails++; $display("FAIL wrap_addr got %0d exp 0", buf_addr); end
        rd_pulse(); rd_pulse();
        zpu_data_rd = 1'b1; tick();
        zpu_data_rd = 1'b0; zpu_io_wr = 1'b1; tick(); zpu_io_wr = 1'b0;
        tests++; if (buf_addr !== 9'd0) begin fails++; $display("FAIL io_wr_override got %0d exp 0", buf_addr); end
    endtask

    task automatic test_block_read();
        zpu_block_rd = 1'b1; tick();
        tests++; if (sd_rd !== 1'b1 || zpu_status[0] !== 1'b0) begin fails++; $display("FAIL blk_rd_req got rd=%b done=%b exp 1/0", sd_rd, zpu_status[0]); end
        tick(); tick();
        tests++; if (sd_rd !== 1'b1) begin fails++; $display("FAIL blk_rd_hold got %b exp 1", sd_rd); end
        sd_ack = 1'b1; tick();
        tests++; if (sd_rd !== 1'b0 || zpu_status[0] !== 1'b0) begin fails++; $display("FAIL blk_ack got rd=%b done=%b exp 0/0", sd_rd, zpu_status[0]); end
        zpu_block_wr = 1'b1; tick(); tick();
        tests++; if (sd_wr !== 1'b0 || zpu_status[0] !== 1'b0) begin fails++; $display("FAIL wr_in_xfer got wr=%b done=%b exp 0/0", sd_wr, zpu_status[0]); end
        sd_ack = 1'b0; tick();
        tests++; if (zpu_status[0] !== 1'b1 || sd_wr !== 1'b0) begin fails++; $display("FAIL blk_done got done=%b wr=%b exp 1/0", zpu_status[0], sd_wr); end
        tick();
        tests++; if (sd_wr !== 1'b0) begin fails++; $display("FAIL wr_not_queued got %b exp 0", sd_wr); end
        zpu_block_rd = 1'b0; zpu_block_wr = 1'b0; tick();
    endtask

    task automatic test_simultaneous();
        zpu_block_rd = 1'b1; zpu_block_wr = 1'b1; tick();
        tests++; if (sd_rd !== 1'b1 || sd_wr !== 1'b0) begin fails++; $display("FAIL rd_wins got rd=%b wr=%b exp 1/0", sd_rd, sd_wr); end
        sd_ack = 1'b1; tick(); sd_ack = 1'b0; tick();
        zpu_block_rd = 1'b0; zpu_block_wr = 1'b0; tick();
        tests++; if (zpu_status[0] !== 1'b1 || sd_wr !== 1'b0) begin fails++; $display("FAIL rd_wins_done got done=%b wr=%b exp 1/0", zpu_status[0], sd_wr); end
    endtask

    task automatic test_timeout();
        int high_cycles;
        high_cycles = 0;
        zpu_block_wr = 1'b1; tick();
        while (sd_wr === 1'b1 && high_cycles < 40) begin
            high_cycles++;
            tick();
        end
        tests++; if (high_cycles != 16) begin fails++; $display("FAIL timeout_len got %0d exp 16", high_cycles); end
        tests++; if (io_err !== 1'b1 || zpu_status[0] !== 1'b1) begin fails++; $display("FAIL timeout_flags got err=%b done=%b exp 1/1", io_err, zpu_status[0]); end
        zpu_block_wr = 1'b0; tick(); tick();
        tests++; if (io_err !== 1'b1) begin fails++; $display("FAIL err_sticky got %b exp 1", io_err); end
        zpu_block_rd = 1'b1; tick();
        tests++; if (io_err !== 1'b0 || sd_rd !== 1'b1) begin fails++; $display("FAIL err_clear got err=%b rd=%b exp 0/1", io_err, sd_rd); end
        sd_ack = 1'b1; tick(); sd_ack = 1'b0; tick();
        zpu_block_rd = 1'b0; tick();
    endtask

    task automatic test_mount();
        ioctl_index = 8'h40; img_size = 64'h2000; img_mounted = 1'b1; tick();
        tests++; if (zpu_status !== 8'hA1) begin fails++; $display("FAIL mount_status got %h exp a1", zpu_status); end
        zpu_lba_sel = 1'b1; #1;
        tests++; if (zpu_rdata !== 32'h2000) begin fails++; $display("FAIL mount_filesize got %h exp 2000", zpu_rdata); end
        zpu_lba_sel = 1'b0;
        tick();
        tests++; if (zpu_status !== 8'hA1) begin fails++; $display("FAIL mount_level got %h exp a1", zpu_status); end
        img_mounted = 1'b0; tick(); img_mounted = 1'b1; tick();
        tests++; if (zpu_status !== 8'hA3) begin fails++; $display("FAIL mount_toggle got %h exp a3", zpu_status); end
        img_mounted = 1'b0; tick();
    endtask

    task automatic test_reset_abandon();
        zpu_block_rd = 1'b1; tick();
        tests++; if (sd_rd !== 1'b1) begin fails++; $display("FAIL abandon_req got %b exp 1", sd_rd); end
        img_size = 64'd0; reset = 1'b1; tick(); reset = 1'b0;
        tests++; if (sd_rd !== 1'b0 || zpu_status !== 8'h01) begin fails++; $display("FAIL abandon got rd=%b status=%h exp 0/01", sd_rd, zpu_status); end
        tick(); tick();
        tests++; if (sd_rd !== 1'b0) begin fails++; $display("FAIL no_edge_after_reset got %b exp 0", sd_rd); end
        zpu_block_rd = 1'b0; tick();
    endtask

    initial begin
        test_reset();
        test_lba_write();
        test_buf_write();
        test_read_and_wrap();
        test_block_read();
        test_simultaneous();
        test_timeout();
        test_mount();
        test_reset_abandon();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/zpu_sd_bridge.md
Name: zpu_sd_bridge

Overview:
- Bridges the ZPU firmware I/O registers to the hps_io SD block interface and the 512-byte sector buffer (port B of the SD dual-port RAM).
- Captures the LBA, sequences block read/write requests with the sd_rd/sd_wr/sd_ack handshake, and auto-increments the buffer address on ZPU data accesses.
- Tracks image mount state and presents status and readback words to the ZPU.
- Sits between the atari5200top ZPU ports and the hps_io/sdbuf instances in the emu top level.

Parameters:
- ACK_TIMEOUT, 24'd0 — cycles to wait for sd_ack after a request before aborting; 0 disables the timeout.

Ports:
- clk_sys  in  1  system clock; everything is sampled on the rising edge.
- reset  in  1  synchronous, active-high reset.
- zpu_lba_sel  in  1  ZPU_OUT2[0]; selects LBA/filesize instead of buffer data.
- zpu_block_rd  in  1  ZPU_OUT2[1], level; a rising edge requests a sector read.
- zpu_block_wr  in  1  ZPU_OUT2[2], level; a rising edge requests a sector write.
- zpu_io_wr  in  1  ZPU_WR[5]; resets the buffer address while high.
- zpu_data_wr  in  1  ZPU_WR[6], data write strobe.
- zpu_data_rd  in  1  ZPU_RD[2], data read strobe.
- zpu_wdata  in  32  ZPU_OUT3.
- zpu_status  out  8  {readonly, filetype[1:0], fileno[2:0], mounted, io_done}.
- zpu_rdata  out  32  lba_sel ? filesize : {24'd0, buf_q}; combinational.
- io_err  out  1  sticky timeout flag.
- sd_lba  out  32  sector address to hps_io.
- sd_rd  out  1  read request to hps_io.
- sd_wr  out  1  write request to hps_io.
- sd_ack  in  1  hps_io acknowledge.
- buf_addr  out  9  sector buffer port-B address.
- buf_wdata  out  8  zpu_wdata[7:0], registered together with buf_we.
- buf_we  out  1  single-cycle buffer write enable.
- buf_q  in  8  sector buffer read data.
- img_mounted  in  1  mount strobe from hps_io.
- img_size  in  64  mounted image size.
- ioctl_index  in  8  file type index from hps_io.

Behaviour:
- Reset values:
  - sd_rd = sd_wr = buf_we = io_err = 0; buf_addr = 0; sd_lba = 0.
  - io_done = 1; fileno = 0; filetype = 0; readonly = 0; filesize = 0.
  - mounted = |img_size[31:0], evaluated every reset cycle.
  - FSM returns to IDLE; a request in flight is abandoned with no done pulse.
  - Edge detectors load their current inputs, so no edge is seen on the first cycle after reset.
- Data write path:
  - zpu_data_wr is delayed by two registers (d1, d2). The event is d1 & ~d2, i.e. the core acts 2 cycles after the strobe rises.
  - On the event with lba_sel=1: sd_lba <= zpu_wdata.
  - On the event with lba_sel=0: buf_we = 1 for exactly one cycle, at the current buf_addr. buf_addr increments on the cycle after buf_we.
- Data read path: on the falling edge of zpu_data_rd (prev=1, now=0), buf_addr increments by 1.
- Address rules:
  - buf_addr wraps from 511 to 0.
  - zpu_io_wr=1 forces buf_addr <= 0 and overrides any increment in the same cycle.
- FSM: IDLE → REQ → XFER → IDLE.
  - IDLE:
    - Rising edge of block_rd: sd_rd=1, io_done=0, go to REQ.
    - Rising edge of block_wr (no read edge): sd_wr=1, io_done=0, go to REQ.
    - Simultaneous read and write edges: the read wins and the write edge is discarded.
  - REQ:
    - On sd_ack=1: clear sd_rd/sd_wr in that same cycle and go to XFER.
    - If ACK_TIMEOUT ≠ 0 and the wait counter reaches ACK_TIMEOUT: clear the request, set io_err=1 and io_done=1, go to IDLE.
  - XFER: on sd_ack falling edge, io_done=1 and go to IDLE.
  - Block rd/wr edges outside IDLE are ignored (not queued).
  - io_err clears on the next accepted request.
- Mount handling, on a rising edge of img_mounted (any FSM state):
  - fileno <= 0, filetype <= ioctl_index[7:6], readonly <= 1.
  - mounted <= ~mounted, filesize <= img_size[31:0].
- Buffer data writes and address updates work in every FSM state; firmware is responsible for not touching the buffer during XFER.

Test Plan:
- Reset with img_size=16384 → mounted=1, io_done=1, status=8'h03, sd_rd=0, buf_addr=0.
- lba_sel=1, wdata=32'h0000_0123, data_wr pulse → sd_lba=32'h123 exactly 2 cycles later, buf_we never asserted.
- io_wr, then 3 data_wr pulses with 8'hA1/A2/A3 → buf_we at addresses 0,1,2 with matching data; buf_addr=3. Starting from 511, a write wraps the address to 0.
- block_rd rising; sd_ack high 3 cycles after sd_rd → sd_rd drops the cycle ack is seen, io_done=0 until ack falls, then 1. A block_wr edge during XFER produces no sd_wr.
- ACK_TIMEOUT=16, block_wr with no ack → sd_wr cleared at cycle 16, io_err=1, io_done=1.
- img_mounted rising with ioctl_index=8'h40, img_size=32'h2000 → filetype=1, readonly=1, mounted toggled; zpu_rdata with lba_sel=1 reads 32'h2000.
